mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Load/store unit at the consumer end of the EX/MEM pipeline register. It takes the MEM-stage
//  address, store data and control, and runs a valid/ready request plus response transaction on
//  the data-memory bus. It stalls the pipeline until the access completes, then presents
//  aligned, sign/zero-extended load data to the MEM/WB register.
// PARAMETERS
//  WIDTH  32  data/address width; only 32 is supported (4 byte lanes)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      synchronous, active-low reset
//  ALUResult_M     in   WIDTH  effective byte address
//  WriteData_M     in   WIDTH  store data (rs2)
//  MemWrite_M      in   1      store instruction in MEM
//  MemRead_M       in   1      load instruction in MEM
//  Funct3_M        in   3      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ReadData_M      out  WIDTH  registered, extended load result; valid from DONE onward
//  Stall_M         out  1      to hazard unit; freezes PC..EX/MEM while high
//  MisalignErr_M   out  1      one-cycle misalignment flag (tied 0 without macro)
//  dmem_req_valid  out  1      bus request valid
//  dmem_req_ready  in   1      bus accepts request
//  dmem_req_we     out  1      1 = write
//  dmem_req_addr   out  WIDTH  word address {addr[31:2],2'b00}
//  dmem_req_wdata  out  WIDTH  lane-replicated store data
//  dmem_req_be     out  4      byte enables
//  dmem_rsp_valid  in   1      read data valid; never in the same cycle as acceptance
//  dmem_rsp_rdata  in   WIDTH  read word
// BEHAVIOUR
//  - FSM IDLE -> REQ -> (WAIT, loads only) -> DONE -> IDLE. Access = MemRead_M|MemWrite_M.
//    If both are set, the access is a store.
//  - IDLE: an access drives Stall_M=1 combinationally; next state is REQ.
//  - REQ: dmem_req_valid=1 with addr/we/be/wdata held stable; Stall_M=1.
//    On valid&ready: a store goes to DONE, a load goes to WAIT.
//  - WAIT: Stall_M=1. On dmem_rsp_valid, extract the lane, extend, register into ReadData_M,
//    then go to DONE.
//  - DONE: Stall_M=0 for exactly one cycle so the pipeline advances; next state is IDLE.
//  - Minimum latency with ready and rsp tied high: store 2 stall cycles; load 3 stall cycles
//    (IDLE, REQ, WAIT).
//  - Store lanes:
//    - SB: be=1<<a[1:0], wdata={4{d[7:0]}}
//    - SH: be=a[1]?1100:0011, wdata={2{d[15:0]}}
//    - SW: be=1111
//  - Loads: B/H are sign-extended, BU/HU are zero-extended. An undefined funct3 is treated as W.
//  - Reset (rst_n=0 at a clk edge): state=IDLE, Stall_M=0, dmem_req_valid=0, ReadData_M=0,
//    MisalignErr_M=0. A response that arrives while in IDLE or REQ is ignored.
//  - An access held low in IDLE produces no bus activity. ReadData_M holds its value until the
//    next load's DONE.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined:
//    - A misaligned access is detected: H with a[0]=1, or W with a[1:0]!=0.
//    - It goes IDLE -> DONE with no bus request.
//    - MisalignErr_M=1 in the DONE cycle only; a misaligned load writes ReadData_M=0.
//  LSU_MISALIGN_CHECK_EN undefined:
//    - MisalignErr_M is tied 0.
//    - H uses a[1] only; W ignores a[1:0]. Every access goes to the bus.
// STRUCTURE
//  - Package lsu_pkg: funct3 localparams (F3_LB..F3_LHU) and the FSM typedef
//    enum {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE}.
//  - Sub-module lsu_load_align, combinational: inputs rdata, a[1:0] and funct3; output is the
//    extended WIDTH-bit result.
// TESTING
//  1. SW 0xDEADBEEF @0x100, ready high:
//     -> one request: we=1, be=1111, addr=0x100.
//     -> Stall high 2 cycles, then low 1 cycle.
//  2. SB 0x000000A5 @0x103, ready low 3 cycles:
//     -> valid and payload stable until ready.
//     -> be=1000, wdata=0xA5A5A5A5.
//  3. LB @0x102, rdata=0x00800000:
//     -> ReadData_M=0xFFFFFF80; LBU gives 0x00000080; LHU @0x102 gives 0x00000080.
//  4. LW with rsp delayed 5 cycles:
//     -> Stall stays high throughout WAIT; DONE is exactly one cycle.
//     -> Back-to-back load+store both complete.
//  5. rst_n low during WAIT, then rsp_valid:
//     -> IDLE, outputs at reset values, response ignored.
//  6. LW @0x101:
//     -> with LSU_MISALIGN_CHECK_EN: no request, MisalignErr_M pulses, ReadData_M=0.
//     -> without the macro: request to 0x100.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store encodings and LSU FSM state type.
// Optional misalignment checking is enabled with LSU_MISALIGN_CHECK_EN (see mem_stage_lsu).
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load lane extraction and sign/zero extension of a 32-bit read word.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [2:0]       funct3_i,
    output logic [WIDTH-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Halfwords pick by a[1] only; a[0] never shifts the lane.
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   result_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result_o = {{(WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   result_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  result_o = {{(WIDTH-16){1'b0}}, half_sel};
            F3_LW:   result_o = rdata_i;
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: stalls the pipeline across a valid/ready data-bus transaction.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses without touching the bus.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ALUResult_M,
    input  logic [WIDTH-1:0] WriteData_M,
    input  logic             MemWrite_M,
    input  logic             MemRead_M,
    input  logic [2:0]       Funct3_M,
    output logic [WIDTH-1:0] ReadData_M,
    output logic             Stall_M,
    output logic             MisalignErr_M,
    output logic             dmem_req_valid,
    input  logic             dmem_req_ready,
    output logic             dmem_req_we,
    output logic [WIDTH-1:0] dmem_req_addr,
    output logic [WIDTH-1:0] dmem_req_wdata,
    output logic [3:0]       dmem_req_be,
    input  logic             dmem_rsp_valid,
    input  logic [WIDTH-1:0] dmem_rsp_rdata
);

    lsu_state_e       state_q, state_d;
    logic             access, size_b, size_h, misalign;
    logic [1:0]       a_lo;
    logic [3:0]       be_d, be_q;
    logic [WIDTH-1:0] wdata_d, wdata_q, addr_q, rdata_q, load_ext;
    logic             we_q, err_q;
    logic [2:0]       f3_q;
    logic [1:0]       alo_q;

    assign access = MemRead_M | MemWrite_M;
    assign a_lo   = ALUResult_M[1:0];
    assign size_b = (Funct3_M[1:0] == 2'b00);
    assign size_h = (Funct3_M[1:0] == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (size_h & a_lo[0]) | (~size_b & ~size_h & (a_lo != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = WriteData_M;
        if (size_b) begin
            be_d    = 4'b0001 << a_lo;
            wdata_d = {4{WriteData_M[7:0]}};
        end else if (size_h) begin
            be_d    = a_lo[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{WriteData_M[15:0]}};
        end
    end

    always_comb begin
        state_d        = state_q;
        Stall_M        = 1'b0;
        dmem_req_valid = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                Stall_M = access;
                if (access) state_d = misalign ? LSU_DONE : LSU_REQ;
            end
            LSU_REQ: begin
                Stall_M        = 1'b1;
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) state_d = we_q ? LSU_DONE : LSU_WAIT;
            end
            LSU_WAIT: begin
                Stall_M = 1'b1;
                if (dmem_rsp_valid) state_d = LSU_DONE;
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    lsu_load_align #(.WIDTH(WIDTH)) u_align (
        .rdata_i   (dmem_rsp_rdata),
        .addr_lo_i (alo_q),
        .funct3_i  (f3_q),
        .result_o  (load_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            alo_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            // Latch the payload once so the bus sees it stable however long ready is held off.
            if (state_q == LSU_IDLE && access) begin
                addr_q  <= {ALUResult_M[WIDTH-1:2], 2'b00};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= MemWrite_M;
                f3_q    <= Funct3_M;
                alo_q   <= a_lo;
                if (misalign) begin
                    err_q <= 1'b1;
                    if (!MemWrite_M) rdata_q <= '0;
                end
            end
            if (state_q == LSU_WAIT && dmem_rsp_valid) rdata_q <= load_ext;
        end
    end

    assign ReadData_M     = rdata_q;
    assign MisalignErr_M  = err_q;
    assign dmem_req_we    = we_q;
    assign dmem_req_addr  = addr_q;
    assign dmem_req_wdata = wdata_q;
    assign dmem_req_be    = be_q;

endmodule
